instr_fetch_unit: RTL and testbench

// Front-end fetch stage ahead of decode: issues pipelined reads to instruction memory.

---
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/instr_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch unit bus bundle.
// Groups the instruction-memory request/response channel, the execute-stage
// redirect input and the decode-side valid/ready channel.
//   master : the fetch unit (drives imem_req/addr, if_*, misalign_err)
//   slave  : the surrounding environment (memory, execute, decode)
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        misalign_err;

   modport master (
      output imem_req, imem_addr, if_valid, if_pc, if_instr, misalign_err,
      input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
   );

   modport slave (
      input  imem_req, imem_addr, if_valid, if_pc, if_instr, misalign_err,
      output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Front-end fetch stage.
// Issues pipelined word reads to instruction memory, remembers the address of
// every granted read in a PC queue, pairs returning data with its PC and
// buffers {pc, instr} in a prefetch FIFO presented to decode over valid/ready.
// A redirect flushes the FIFO, marks every read still in flight as stale
// (discarded on return) and restarts fetch at the new PC. A misaligned
// redirect parks the unit in HALT with misalign_err set until an aligned
// redirect arrives.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      instr_fetch_unit_if.master (imem_*, redirect_*, if_*, misalign_err)
module instr_fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   instr_fetch_unit_if.master    bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {FETCH, HALT} state_t;

   state_t                    state_q,    state_d;
   logic                      req_q,      req_d;
   logic [31:0]               addr_q,     addr_d;
   logic                      mis_q,      mis_d;
   logic [CW-1:0]             out_q,      out_d;
   logic [CW-1:0]             drop_q,     drop_d;
   logic [CW-1:0]             cnt_q,      cnt_d;
   logic [AW-1:0]             rd_q,       rd_d;
   logic [AW-1:0]             wr_q,       wr_d;
   logic [AW-1:0]             pcq_rd_q,   pcq_rd_d;
   logic [AW-1:0]             pcq_wr_q,   pcq_wr_d;
   logic [DEPTH-1:0][31:0]    pcq_q,      pcq_d;
   logic [DEPTH-1:0][31:0]    fifo_pc_q,  fifo_pc_d;
   logic [DEPTH-1:0][31:0]    fifo_ins_q, fifo_ins_d;

   logic        grant, push, pop, if_valid_w;
   logic [CW:0] credit_sum;

   // Head is hidden during a redirect so decode can never consume it.
   assign if_valid_w = (cnt_q != '0) && (state_q == FETCH) && !bus.redirect_valid;

   assign bus.imem_req     = req_q;
   assign bus.imem_addr    = addr_q;
   assign bus.if_valid     = if_valid_w;
   assign bus.if_pc        = fifo_pc_q[rd_q];
   assign bus.if_instr     = fifo_ins_q[rd_q];
   assign bus.misalign_err = mis_q;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      mis_d      = mis_q;
      drop_d     = drop_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      pcq_rd_d   = pcq_rd_q;
      pcq_wr_d   = pcq_wr_q;
      pcq_d      = pcq_q;
      fifo_pc_d  = fifo_pc_q;
      fifo_ins_d = fifo_ins_q;

      grant = req_q && bus.imem_gnt;
      push  = bus.imem_rvalid && (drop_q == '0) && !bus.redirect_valid;
      pop   = if_valid_w && bus.if_ready;

      out_d = out_q + CW'(grant) - CW'(bus.imem_rvalid);
      cnt_d = cnt_q + CW'(push) - CW'(pop);

      if (grant) begin
         pcq_d[pcq_wr_q] = addr_q;
         pcq_wr_d        = pcq_wr_q + AW'(1);
         addr_d          = addr_q + 32'd4;
      end

      // Responses return in grant order, so the PC queue head always
      // belongs to the word arriving now, stale or not.
      if (bus.imem_rvalid) begin
         pcq_rd_d = pcq_rd_q + AW'(1);
         if (drop_q != '0)
            drop_d = drop_q - CW'(1);
      end

      if (push) begin
         fifo_pc_d[wr_q]  = pcq_q[pcq_rd_q];
         fifo_ins_d[wr_q] = bus.imem_rdata;
         wr_d             = wr_q + AW'(1);
      end

      if (pop)
         rd_d = rd_q + AW'(1);

      // Everything still in flight after this cycle's grant/return is stale,
      // including a grant taken in the redirect cycle itself.
      if (bus.redirect_valid) begin
         rd_d   = '0;
         wr_d   = '0;
         cnt_d  = '0;
         drop_d = out_d;
         if (bus.redirect_pc[1:0] != 2'b00) begin
            mis_d   = 1'b1;
            state_d = HALT;
         end else begin
            mis_d   = 1'b0;
            state_d = FETCH;
            addr_d  = bus.redirect_pc;
         end
      end

      // Credit: buffered words plus reads in flight never exceed DEPTH,
      // so every return has a FIFO slot waiting for it.
      credit_sum = {1'b0, cnt_d} + {1'b0, out_d};
      req_d      = (state_d == FETCH) && (credit_sum < (CW+1)'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= FETCH;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC;
         mis_q      <= 1'b0;
         out_q      <= '0;
         drop_q     <= '0;
         cnt_q      <= '0;
         rd_q       <= '0;
         wr_q       <= '0;
         pcq_rd_q   <= '0;
         pcq_wr_q   <= '0;
         pcq_q      <= '0;
         fifo_pc_q  <= '0;
         fifo_ins_q <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         mis_q      <= mis_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         pcq_rd_q   <= pcq_rd_d;
         pcq_wr_q   <= pcq_wr_d;
         pcq_q      <= pcq_d;
         fifo_pc_q  <= fifo_pc_d;
         fifo_ins_q <= fifo_ins_d;
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: table of per-cycle vectors for reset,
// streaming and backpressure, then hand-written redirect / misalign / stall /
// reset sequences. A handshake scoreboard checks every delivered {pc, instr}
// against the expected PC stream.
module tb_instr_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam logic [31:0] K        = 32'h5A5A_0000;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   instr_fetch_unit_if bus();

   instr_fetch_unit #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   int passed = 0;
   int total  = 0;
   logic [31:0] exp_pc = RESET_PC;

   // Memory model: grant when gnt_en, data lat cycles after grant, in order.
   typedef struct { logic [31:0] a; int due; } rd_t;
   rd_t  mq[$];
   int   cyc = 0;
   int   lat = 1;
   logic gnt_en = 1'b1;

   assign bus.imem_gnt = gnt_en;

   always @(posedge clk) begin
      if (!reset_n) mq.delete();
      else begin
         if (bus.imem_rvalid && mq.size() > 0) void'(mq.pop_front());
         if (bus.imem_req && bus.imem_gnt) mq.push_back('{bus.imem_addr, cyc + lat});
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = mq[0].a ^ K;
      end else begin
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata  = '0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
   endtask

   // One cycle: drive at negedge, sample 1 time unit later, score handshakes.
   task automatic step(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
      @(negedge clk);
      reset_n            = rst;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.if_ready       = rdy;
      #1;
      if (rst && bus.if_valid && rdy) begin
         chk("deliver_pc", bus.if_pc, exp_pc);
         chk("deliver_instr", bus.if_instr, exp_pc ^ K);
         exp_pc = exp_pc + 32'd4;
      end
      if (!rst) exp_pc = RESET_PC;
      else if (rv && rpc[1:0] == 2'b00) exp_pc = rpc;
   endtask

   task automatic wait_valid(input string nm, input logic [31:0] epc);
      logic got = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step(1'b1, 1'b0, 32'h0, 1'b1);
         if (bus.if_valid) begin
            got = 1'b1;
            break;
         end
      end
      chk({nm, "_seen"}, 32'(got), 32'h1);
      if (got) chk({nm, "_pc"}, bus.if_pc, epc);
   endtask

   typedef struct {
      logic        rst, rdy, chk, ev;
      logic [31:0] epc;
      logic        ereq;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(input logic rst, input logic rdy, input logic c,
                               input logic ev, input logic [31:0] epc, input logic ereq);
      vec_t v;
      v = '{rst, rdy, c, ev, epc, ereq};
      return v;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rec;
      reset_n            = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.if_ready       = 1'b1;

      // Reset, 1-cycle memory, streaming, then 10 cycles of backpressure.
      tbl.push_back(mk(0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 1));
      tbl.push_back(mk(1, 1, 1, 0, 0, 1));
      for (int k = 5; k <= 8; k++) tbl.push_back(mk(1, 1, 1, 1, 32'(4*(k-5)), 1));
      tbl.push_back(mk(1, 0, 1, 1, 32'd16, 1));
      tbl.push_back(mk(1, 0, 1, 1, 32'd16, 1));
      for (int k = 11; k <= 18; k++) tbl.push_back(mk(1, 0, 1, 1, 32'd16, 0));
      tbl.push_back(mk(1, 1, 1, 1, 32'd16, 0));
      for (int k = 20; k <= 24; k++) tbl.push_back(mk(1, 1, 1, 1, 32'(20 + 4*(k-20)), 1));

      foreach (tbl[i]) begin
         step(tbl[i].rst, 1'b0, 32'h0, tbl[i].rdy);
         if (tbl[i].chk) begin
            chk($sformatf("vec%0d_valid", i), 32'(bus.if_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_req", i), 32'(bus.imem_req), 32'(tbl[i].ereq));
            chk($sformatf("vec%0d_mis", i), 32'(bus.misalign_err), 32'h0);
            if (tbl[i].ev || !tbl[i].rst) begin
               chk($sformatf("vec%0d_pc", i), bus.if_pc, tbl[i].epc);
               chk($sformatf("vec%0d_instr", i), bus.if_instr,
                   tbl[i].rst ? (tbl[i].epc ^ K) : 32'h0);
            end
            if (!tbl[i].rst) chk($sformatf("vec%0d_addr", i), bus.imem_addr, RESET_PC);
         end
      end

      // Redirect to 0x40 with 3 slow reads in flight.
      lat = 4;
      step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      for (int s = 0; s < 4; s++) step(1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b1, 32'h40, 1'b1);
      chk("redir40_valid_low", 32'(bus.if_valid), 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b1);
      chk("redir40_addr", bus.imem_addr, 32'h40);
      wait_valid("redir40", 32'h40);

      // Redirect in a cycle where decode is accepting.
      lat = 1;
      for (int s = 0; s < 8; s++) step(1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b1, 32'h100, 1'b1);
      chk("redir_hs_valid_low", 32'(bus.if_valid), 32'h0);
      wait_valid("redir_hs", 32'h100);

      // Ungranted request: address and request must hold.
      gnt_en = 1'b0;
      rec = bus.imem_addr;
      for (int s = 0; s < 3; s++) begin
         step(1'b1, 1'b0, 32'h0, 1'b1);
         chk($sformatf("stall%0d_addr", s), bus.imem_addr, rec);
         chk($sformatf("stall%0d_req", s), 32'(bus.imem_req), 32'h1);
      end
      gnt_en = 1'b1;
      for (int s = 0; s < 4; s++) step(1'b1, 1'b0, 32'h0, 1'b1);

      // Misaligned redirect halts; aligned redirect resumes.
      step(1'b1, 1'b1, 32'h42, 1'b1);
      for (int s = 0; s < 4; s++) begin
         step(1'b1, 1'b0, 32'h0, 1'b1);
         chk($sformatf("halt%0d_mis", s), 32'(bus.misalign_err), 32'h1);
         chk($sformatf("halt%0d_req", s), 32'(bus.imem_req), 32'h0);
         chk($sformatf("halt%0d_valid", s), 32'(bus.if_valid), 32'h0);
      end
      step(1'b1, 1'b1, 32'h80, 1'b1);
      step(1'b1, 1'b0, 32'h0, 1'b1);
      chk("resume_mis", 32'(bus.misalign_err), 32'h0);
      wait_valid("resume80", 32'h80);

      // Reset with reads outstanding and words buffered.
      lat = 3;
      for (int s = 0; s < 6; s++) step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      chk("rst_valid", 32'(bus.if_valid), 32'h0);
      chk("rst_req", 32'(bus.imem_req), 32'h0);
      chk("rst_addr", bus.imem_addr, RESET_PC);
      chk("rst_pc", bus.if_pc, 32'h0);
      chk("rst_instr", bus.if_instr, 32'h0);
      chk("rst_mis", 32'(bus.misalign_err), 32'h0);
      lat = 1;
      wait_valid("post_rst", RESET_PC);
      for (int s = 0; s < 6; s++) step(1'b1, 1'b0, 32'h0, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
